instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//  Inverse of the instruction decoder: packs RISC-V RV32I fields (op, rd, rs1, rs2, funct3, funct7, imm, instrType)
//  into 32-bit instruction words. Words are buffered in a small FIFO and streamed to the instruction-memory write port
//  with an auto-incrementing address. Used by the self-test/program loader to build code in IMEM.
// PARAMETERS
//  FIFO_DEPTH  2            output FIFO entries, power of 2, >=2
//  ADDR_W      32           width of write address counter
//  BASE_ADDR   32'h0        address written first after reset / addr_clr
// PORTS
//  clk         in   1       clock, rising edge
//  reset       in   1       asynchronous, active-high reset
//  in_valid    in   1       field bundle valid
//  in_ready    out  1       encoder can accept (= !fifo_full)
//  instrType   in   3       1=U 2=J 3=B 4=I 5=S 6=R (same coding as decoder); 0,7 illegal
//  op          in   7       opcode, copied to instr[6:0]
//  rd,rs1,rs2  in   5 each  register indices
//  funct3      in   3       funct3
//  funct7      in   7       funct7 (R-type only)
//  imm         in   32      immediate, decoder form (sign-extended byte offset / U value)
//  out_valid   out  1       encoded word available (= !fifo_empty)
//  out_ready   in   1       IMEM accepts word
//  out_addr    out  ADDR_W  address of out_instr
//  out_instr   out  32      encoded instruction word
//  addr_clr    in   1       synchronous: reload address counter with BASE_ADDR
//  err         out  1       sticky: an illegal bundle was dropped
//  err_cnt     out  8       dropped-bundle count, saturates at 255
// BEHAVIOUR
//  Reset (async): FIFO empty, out_valid=0, in_ready=1, addr=BASE_ADDR, err=0, err_cnt=0, out_instr=0.
//  Accept: in_valid & in_ready at edge. Encoding is combinational, word pushed same edge; out_valid next cycle (lat 1).
//  Encoding (fields not used by a format are ignored):
//   U {imm[31:12],rd,op}  J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}  I {imm[11:0],rs1,f3,rd,op}
//   S {imm[11:5],rs2,rs1,f3,imm[4:0],op}  R {f7,rs2,rs1,f3,rd,op}
//  Output: out_addr = address counter; pop on out_valid & out_ready, counter += 4 (wraps mod 2^ADDR_W).
//  addr_clr same cycle as pop: clr wins (next addr = BASE_ADDR). FIFO contents unaffected by addr_clr.
//  Push and pop same cycle: allowed when not full; occupancy unchanged. No bypass: empty FIFO never outputs same cycle.
//  Full: in_ready=0; in_valid held by source. out_addr/out_instr stable while out_valid & !out_ready.
//  Illegal bundle (instrType 0/7, or range fail when checks compiled in): handshake completes (consumed), nothing
//   pushed, err<=1, err_cnt+=1 (sat). err clears only on reset.
//  Mid-operation reset: all FIFO entries discarded, no partial word emitted.
// CONFIGURATION
//  ENC_RANGE_CHECK_EN defined: bundle also illegal if imm does not fit format:
//   I/S: imm not sign-ext of 12 bits; B: not 13-bit signed or imm[0]=1; J: not 21-bit signed or imm[0]=1;
//   U: imm[11:0]!=0.
//  Not defined: only instrType 0/7 illegal; out-of-range imm silently truncated to the format bits above.
// TESTING
//  I addi x1,x0,5 (type4,op13,f3 0,imm 5) -> out_instr 32'h00500093 at out_addr 0, one cycle after accept.
//  U lui x5,imm 32'h12345000; J jal x1,+8 -> 32'h123452B7 @0, 32'h008000EF @4.
//  B beq x1,x2,+16; S sw x2,4(x1) f3 2; R add x3,x1,x2 -> 32'h00208863, 32'h0020A223, 32'h002081B3, addrs +4.
//  out_ready=0, push 3 bundles (depth 2) -> in_ready=0 after 2nd; release -> 3 words in order, no loss/dup.
//  B imm=3 with ENC_RANGE_CHECK_EN -> dropped, err=1, err_cnt=1, out_valid stays 0; without macro -> encoded.
//  instrType 7 -> err_cnt increments; addr_clr during pop -> next out_addr=BASE_ADDR; reset mid-stream -> FIFO empty.

Source files
------------

// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
// Packs RISC-V RV32I field bundles (the inverse of the instruction decoder)
// into 32-bit instruction words. Each word is queued in a small output FIFO
// and streamed to the instruction-memory write port. The write address
// auto-increments by 4 on every word taken.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  field-bundle handshake (in_ready = FIFO not full)
//   instrType            1=U 2=J 3=B 4=I 5=S 6=R; 0 and 7 are illegal
//   op, rd, rs1, rs2,
//   funct3, funct7, imm  instruction fields, imm in decoder (byte-offset) form
//   out_valid/out_ready  word handshake towards IMEM (out_valid = FIFO not empty)
//   out_addr, out_instr  write address and encoded word at the FIFO head
//   addr_clr             synchronous reload of the address counter to BASE_ADDR
//   err, err_cnt         sticky drop flag and saturating drop count
//
// Optional feature: define ENC_RANGE_CHECK_EN to also reject bundles whose
// immediate does not fit the selected format. Without it, out-of-range
// immediates are silently truncated to the format's bits.
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter int                 FIFO_DEPTH = 2,
    parameter int                 ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        instrType,
    input  logic [6:0]        op,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_instr,
    input  logic              addr_clr,
    output logic              err,
    output logic [7:0]        err_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // Encode one bundle; bits a format does not use are ignored.
    function automatic logic [31:0] encode_word(
        input logic [2:0]  t,
        input logic [6:0]  o,
        input logic [4:0]  d,
        input logic [4:0]  s1,
        input logic [4:0]  s2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] v
    );
        logic [31:0] w;
        case (t)
            3'd1:    w = {v[31:12], d, o};
            3'd2:    w = {v[20], v[10:1], v[11], v[19:12], d, o};
            3'd3:    w = {v[12], v[10:5], s2, s1, f3, v[4:1], v[11], o};
            3'd4:    w = {v[11:0], s1, f3, d, o};
            3'd5:    w = {v[11:5], s2, s1, f3, v[4:0], o};
            3'd6:    w = {f7, s2, s1, f3, d, o};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // A bundle is legal when its type is 1..6 and, with range checks
    // compiled in, the immediate is representable in the format.
    function automatic logic bundle_legal(
        input logic [2:0]  t,
        input logic [31:0] v
    );
        logic ok;
        case (t)
`ifdef ENC_RANGE_CHECK_EN
            3'd1:    ok = (v[11:0] == 12'h000);
            3'd2:    ok = (v[31:20] == {12{v[20]}}) && (v[0] == 1'b0);
            3'd3:    ok = (v[31:12] == {20{v[12]}}) && (v[0] == 1'b0);
            3'd4:    ok = (v[31:11] == {21{v[11]}});
            3'd5:    ok = (v[31:11] == {21{v[11]}});
            3'd6:    ok = 1'b1;
`else
            3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    logic [31:0]       fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              err_q, err_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic              full_s, empty_s, accept_s, legal_s, push_s, pop_s;
    logic [31:0]       word_s;

    assign full_s   = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_s  = (count_q == CNT_W'(0));
    assign accept_s = in_valid & ~full_s;
    assign legal_s  = bundle_legal(instrType, imm);
    assign word_s   = encode_word(instrType, op, rd, rs1, rs2, funct3, funct7, imm);
    // Illegal bundles still complete the handshake; they just never enter the FIFO.
    assign push_s   = accept_s & legal_s;
    assign pop_s    = ~empty_s & out_ready;

    assign in_ready  = ~full_s;
    assign out_valid = ~empty_s;
    assign out_addr  = addr_q;
    assign out_instr = fifo_q[rd_ptr_q];
    assign err       = err_q;
    assign err_cnt   = err_cnt_q;

    // Next-state for FIFO pointers/occupancy, address counter and error tracking.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        addr_d    = addr_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A reload request wins over the post-pop increment.
        if (addr_clr) begin
            addr_d = BASE_ADDR;
        end else if (pop_s) begin
            addr_d = addr_q + ADDR_W'(32'd4);
        end else begin
            addr_d = addr_q;
        end

        if (accept_s && !legal_s) begin
            err_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
        end else begin
            err_d     = err_q;
            err_cnt_d = err_cnt_q;
        end
    end

    // Control/status state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            addr_q    <= BASE_ADDR;
            err_q     <= 1'b0;
            err_cnt_q <= 8'h00;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // FIFO storage; cleared on reset so out_instr reads zero afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            fifo_q[wr_ptr_q] <= word_s;
        end
    end

endmodule
